jtag_userop_dispatch: RTL

//  Command sequencer on the user side of the jtaglet TAP, in the tck domain. Each userOp_ready pulse

---
 rtl/jtag_userop_dispatch_pkg.sv | 62 ++++++
 rtl/jtag_userop_dispatch_if.sv | 29 ++
 rtl/jtag_userop_dispatch_timeout.sv | 36 +++
 rtl/jtag_userop_dispatch.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/jtag_userop_dispatch_pkg.sv
// ----------------------------------------------------------------------------
// jtag_user_pkg : opcodes, status layout and state encoding for the dispatcher
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package jtag_user_pkg;

  localparam logic [7:0] c_op_nop       = 8'h00;
  localparam logic [7:0] c_op_set_addr  = 8'h01;
  localparam logic [7:0] c_op_write     = 8'h02;
  localparam logic [7:0] c_op_read      = 8'h03;
  localparam logic [7:0] c_op_status    = 8'h04;
  localparam logic [7:0] c_op_clr_err   = 8'h05;
  localparam logic [7:0] c_op_write_inc = 8'h12;
  localparam logic [7:0] c_op_read_inc  = 8'h13;

  localparam int c_stat_busy        = 0;
  localparam int c_stat_err_busy    = 1;
  localparam int c_stat_err_opcode  = 2;
  localparam int c_stat_err_timeout = 3;
  localparam int c_stat_cnt_lsb     = 8;
  localparam int c_stat_addr_lsb    = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  function automatic logic is_bus_op(input logic [7:0] op);
    return (op == c_op_write) || (op == c_op_read) ||
           (op == c_op_write_inc) || (op == c_op_read_inc);
  endfunction

  function automatic logic is_write_op(input logic [7:0] op);
    return (op == c_op_write) || (op == c_op_write_inc);
  endfunction

  function automatic logic is_inc_op(input logic [7:0] op);
    return (op == c_op_write_inc) || (op == c_op_read_inc);
  endfunction

  // busy is always 0 here: STATUS only ever executes in IDLE
  function automatic logic [31:0] pack_status(input logic [15:0] addr,
                                              input logic [7:0]  cnt,
                                              input logic        err_timeout,
                                              input logic        err_opcode,
                                              input logic        err_busy);
    logic [31:0] s;
    s = '0;
    s[c_stat_addr_lsb +: 16]   = addr;
    s[c_stat_cnt_lsb +: 8]     = cnt;
    s[c_stat_err_timeout]      = err_timeout;
    s[c_stat_err_opcode]       = err_opcode;
    s[c_stat_err_busy]         = err_busy;
    s[c_stat_busy]             = 1'b0;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_userop_dispatch_if.sv
// ----------------------------------------------------------------------------
// jtag_userop_dispatch_if : req/ack register bus between dispatcher and target
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface jtag_userop_dispatch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

`default_nettype wire

// File: rtl/jtag_userop_dispatch_timeout.sv
// ----------------------------------------------------------------------------
// jtag_bus_timeout : loadable down-counter flagging a bus ack timeout
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtag_bus_timeout #(
  parameter int TIMEOUT = 64
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_expired
);

  localparam logic [15:0] c_load = 16'(TIMEOUT - 1);

  logic [15:0] r_cnt;

  // Loaded with TIMEOUT-1 so that the TIMEOUT-th waiting cycle sees zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= c_load;
    end else if (i_en && (r_cnt != 16'd0)) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  assign o_expired = i_en && (r_cnt == 16'd0);

endmodule

`default_nettype wire

// File: rtl/jtag_userop_dispatch.sv
// ----------------------------------------------------------------------------
// jtag_userop_dispatch : tck-domain sequencer turning TAP user ops into bus cycles
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtag_userop_dispatch
  import jtag_user_pkg::*;
#(
  parameter int USERDATA_LEN = 32,
  parameter int USEROP_LEN   = 8,
  parameter int ADDR_W       = 16,
  parameter int TIMEOUT      = 64
) (
  input  wire logic                    tck,
  input  wire logic                    trst,
  input  wire logic [USEROP_LEN-1:0]   userOp,
  input  wire logic                    userOp_ready,
  input  wire logic [USERDATA_LEN-1:0] userData_out,
  output logic      [USERDATA_LEN-1:0] userData_in,
  jtag_userop_dispatch_if.master       bus
);

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_addr;
  logic [7:0]              r_op_cnt;
  logic                    r_err_timeout;
  logic                    r_err_opcode;
  logic                    r_err_busy;
  logic                    r_req;
  logic                    r_we;
  logic                    r_inc;
  logic [ADDR_W-1:0]       r_bus_addr;
  logic [USERDATA_LEN-1:0] r_wdata;
  logic [USERDATA_LEN-1:0] r_udi;

  logic [7:0]  w_op8;
  logic        w_ack;
  logic        w_expired;
  logic        w_bus_start;
  logic [31:0] w_status;

  assign w_op8       = userOp[7:0];
  assign w_ack       = r_req && bus.bus_ack;
  assign w_bus_start = (r_state == ST_IDLE) && userOp_ready && is_bus_op(w_op8);
  assign w_status    = pack_status(16'(r_addr), r_op_cnt + 8'd1,
                                   r_err_timeout, r_err_opcode, r_err_busy);

  generate
    if (USEROP_LEN > 8) begin : g_op_ext
      logic w_unused_op_hi;
      assign w_unused_op_hi = ^userOp[USEROP_LEN-1:8];
    end
  endgenerate

  jtag_bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (tck),
    .rst       (trst),
    .i_clr     (w_bus_start),
    .i_en      (r_req && !bus.bus_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_op_cnt      <= '0;
      r_err_timeout <= 1'b0;
      r_err_opcode  <= 1'b0;
      r_err_busy    <= 1'b0;
      r_req         <= 1'b0;
      r_we          <= 1'b0;
      r_inc         <= 1'b0;
      r_bus_addr    <= '0;
      r_wdata       <= '0;
      r_udi         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (userOp_ready) begin
            case (w_op8)
              c_op_nop: begin
                r_op_cnt <= r_op_cnt + 8'd1;
              end
              c_op_set_addr: begin
                r_addr   <= userData_out[ADDR_W-1:0];
                r_op_cnt <= r_op_cnt + 8'd1;
              end
              c_op_write, c_op_read, c_op_write_inc, c_op_read_inc: begin
                r_state    <= ST_BUS;
                r_req      <= 1'b1;
                r_we       <= is_write_op(w_op8);
                r_inc      <= is_inc_op(w_op8);
                r_bus_addr <= r_addr;
                r_wdata    <= userData_out;
                r_op_cnt   <= r_op_cnt + 8'd1;
              end
              c_op_status: begin
                r_udi    <= USERDATA_LEN'(w_status);
                r_op_cnt <= r_op_cnt + 8'd1;
              end
              c_op_clr_err: begin
                r_err_timeout <= 1'b0;
                r_err_opcode  <= 1'b0;
                r_err_busy    <= 1'b0;
                r_op_cnt      <= r_op_cnt + 8'd1;
              end
              default: begin
                r_err_opcode <= 1'b1;
              end
            endcase
          end
        end
        ST_BUS: begin
          // A strobe here, even on the ack cycle, is dropped
          if (userOp_ready) begin
            r_err_busy <= 1'b1;
          end
          if (w_ack) begin
            r_req   <= 1'b0;
            r_state <= ST_IDLE;
            if (!r_we) begin
              r_udi <= bus.bus_rdata;
            end
            if (r_inc) begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end else if (w_expired) begin
            r_req         <= 1'b0;
            r_state       <= ST_IDLE;
            r_err_timeout <= 1'b1;
            if (!r_we) begin
              r_udi <= '1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_req   = r_req;
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_wdata;
  assign userData_in   = r_udi;

endmodule

`default_nettype wire
